fir_out_formatter: RTL
======================

# fir_out_formatter

Downstream stage of the 19-tap symmetric FIR filter. Takes the filter's 39-bit unsigned accumulator output, rounds and scales it to 16 bits with saturation, and decimates by a fixed factor. Buffers the results in a small FIFO with a valid/ready handshake toward the sample consumer (serial/packet interface). Sticky status flags report saturation and FIFO overflow to the control logic.

## Interface
- SHIFT, 15: right-shift applied to the accumulator (1..23).
- DEC, 4: decimation factor (1..16); keep 1 of every DEC valid inputs.
- DEPTH, 4: FIFO depth in entries (power of two, 2..16).

- CLK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear of the decimation counter, pipeline, FIFO and flags; has priority over all other inputs.
- IN_VALID  in  1  IN_DATA holds a new filter output this cycle.
- IN_DATA  in  39  unsigned filter output (S6).
- OUT_READY  in  1  consumer accepts OUT_DATA this cycle.
- OUT_VALID  out  1  FIFO not empty.
- OUT_DATA  out  16  FIFO head, valid when OUT_VALID=1.
- FIFO_LEVEL  out  clog2(DEPTH)+1  number of stored entries.
- SAT  out  1  sticky: a kept sample was saturated.
- OVF  out  1  sticky: a kept sample was dropped because the FIFO was full.

## Operation
- Decimation counter dcnt (0..DEC-1) increments on each IN_VALID and wraps DEC-1 -> 0. A sample is kept when IN_VALID=1 and dcnt==0, so the first valid sample after reset/CLR is kept. DEC=1 keeps every sample.
- Round/scale on kept samples only: sum = IN_DATA + 2^(SHIFT-1), computed in 40 bits with no wrap. q = sum >> SHIFT. If q > 0xFFFF, the result is 0xFFFF and SAT is set; otherwise the result is q[15:0].
- Stage register: at the keep edge, stores the result and sets the pending bit p. p clears on the next edge unless another sample is kept.
- FIFO write: when p=1, the stage register is written at the next edge.
  - Read = OUT_VALID & OUT_READY.
  - A write while FIFO_LEVEL==DEPTH and no read in the same cycle is dropped: the FIFO is unchanged and OVF is set.
  - A write while full with a read in the same cycle succeeds, and the level stays at DEPTH.
  - A simultaneous write and read while level==1 leaves level 1 with the new entry at the head.
- FIFO order is strictly first-in first-out. Read and write pointers wrap modulo DEPTH.
- SAT and OVF stay set until CLR or RESET.
- No state machine beyond dcnt, p, and the FIFO pointers/level. The pipeline never stalls. Backpressure causes drops only, never input stalls.

## Timing
- Reset values (asynchronous, RESET=0):
  - OUT_VALID=0, OUT_DATA=0, FIFO_LEVEL=0, SAT=0, OVF=0.
  - dcnt=0, p=0, pointers=0, stage register=0.
- Latency: a sample kept at edge k is written at edge k+1. If the FIFO was empty, OUT_VALID=1 and OUT_DATA is valid after edge k+1, i.e. 2 cycles from input to output.
- SAT rises after the keep edge k. OVF rises after the dropped-write edge k+1.
- Throughput: one kept sample per cycle sustained (DEC=1, OUT_READY=1).
- OUT_DATA is driven from the FIFO storage. It holds stable while OUT_VALID=1 and OUT_READY=0.
- Reset mid-operation: all state clears immediately, and in-flight and stored samples are discarded. CLR does the same at the next edge.
- The same-cycle effect of CLR with IN_VALID: the input is ignored and dcnt=0 afterwards, so the next valid input is kept.

## Test plan
All scenarios use default parameters unless noted.

1. Rounding:
   - DEC=1, OUT_READY=1, inputs 0x0000004000 then 0x0000003FFF -> OUT_DATA 0x0001 then 0x0000, each 2 cycles after its input; SAT=0.
   - Input 0x000000C000 -> 0x0002.
2. Saturation boundary (DEC=1):
   - 0x007FFFBFFF -> 0xFFFF with SAT=0.
   - 0x007FFFC000 -> 0xFFFF with SAT=1.
   - 0x7FFFFFFFFF -> 0xFFFF, SAT stays 1.
3. Decimation: 8 consecutive valid inputs n<<15 for n=1..8 (with gaps of IN_VALID=0 between some) -> exactly two outputs, 0x0001 and 0x0005.
4. Backpressure/overflow (DEC=1, OUT_READY=0):
   - Inputs 1..5 (<<15) -> FIFO_LEVEL reaches 4 and OVF=1 after the 5th write edge.
   - Then OUT_READY=1 -> outputs 1,2,3,4 on consecutive cycles, OUT_VALID=0 afterwards, OVF still 1.
5. Full with simultaneous read/write: FIFO full, OUT_READY=1 while writing a 5th sample -> no drop, level stays 4, OVF=0, output order preserved.
6. Reset/CLR mid-stream:
   - Assert RESET low asynchronously with 3 entries stored -> all outputs return to reset values without a clock edge.
   - Repeat with CLR for one cycle -> same state after the edge, and the next valid input is kept.

Source files
------------

// File: rtl/fir_out_formatter.sv
// Output stage of the 19-tap FIR filter: round/scale the 39-bit accumulator to 16 bits with saturation,
// decimate by DEC, and buffer the results in a small FIFO with a valid/ready handshake.
module fir_out_formatter #(
  parameter int SHIFT = 15,
  parameter int DEC   = 4,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CLR,
  input  logic                     IN_VALID,
  input  logic [38:0]              IN_DATA,
  input  logic                     OUT_READY,
  output logic                     OUT_VALID,
  output logic [15:0]              OUT_DATA,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output logic                     SAT,
  output logic                     OVF
);
  localparam int DW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [39:0]   RND   = 40'd1 << (SHIFT - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEC - 1);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          p_q, p_d;
  logic [15:0]   stage_q, stage_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          sat_q, sat_d, ovf_q, ovf_d;
  logic [15:0]   mem_q [DEPTH];

  logic          keep, rd, wr_ok, q_sat;
  logic [39:0]   sum, q;
  logic [15:0]   res;

  always_comb begin
    keep  = IN_VALID && (dcnt_q == '0);
    sum   = {1'b0, IN_DATA} + RND;
    q     = sum >> SHIFT;
    q_sat = |q[39:16];
    res   = q_sat ? 16'hFFFF : q[15:0];
    rd    = (lvl_q != '0) && OUT_READY;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_ok = p_q && ((lvl_q != FULL) || rd);

    dcnt_d  = dcnt_q;
    p_d     = 1'b0;
    stage_d = stage_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    lvl_d   = lvl_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;

    if (CLR) begin
      dcnt_d  = '0;
      stage_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      lvl_d   = '0;
      sat_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (IN_VALID) dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1;
      p_d = keep;
      if (keep) stage_d = res;
      sat_d = sat_q | (keep & q_sat);
      ovf_d = ovf_q | (p_q & ~wr_ok);
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd)    rptr_d = rptr_q + 1'b1;
      case ({wr_ok, rd})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dcnt_q  <= '0;
      p_q     <= 1'b0;
      stage_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      p_q     <= p_d;
      stage_q <= stage_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      lvl_q   <= lvl_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: OUT_DATA is masked to zero whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (!CLR && wr_ok) mem_q[wptr_q] <= stage_q;
  end

  assign OUT_VALID  = (lvl_q != '0);
  assign OUT_DATA   = OUT_VALID ? mem_q[rptr_q] : 16'h0000;
  assign FIFO_LEVEL = lvl_q;
  assign SAT        = sat_q;
  assign OVF        = ovf_q;
endmodule
